// File: rtl/slot_alloc_pkg.sv
// Shared defaults and width helpers for the slot allocator.
package slot_alloc_pkg;

  localparam int DEFAULT_DEPTH   = 16;
  localparam int DEFAULT_ALLOC_W = 2;
  localparam int DEFAULT_FREE_W  = 2;

  function automatic int calc_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/slot_alloc_prio_enc.sv
// Lowest-set-bit encoder over (vec_i & ~mask_i); onehot_o lets the next stage mask the winner.
module masked_prio_enc
  import slot_alloc_pkg::*;
#(
  parameter int W     = DEFAULT_DEPTH,
  parameter int IDX_W = calc_idx_w(DEFAULT_DEPTH)
) (
  input  logic [W-1:0]     vec_i,
  input  logic [W-1:0]     mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o,
  output logic [W-1:0]     onehot_o
);

  logic [W-1:0] eff;

  assign eff      = vec_i & ~mask_i;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = eff & (~eff + W'(1));
  assign vld_o    = |eff;

  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (eff[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/slot_alloc.sv
// Multi-port slot allocator: busy bitmap, cascaded lowest-free offers, multi-port release.
module slot_alloc
  import slot_alloc_pkg::*;
#(
  parameter int  DEPTH   = DEFAULT_DEPTH,
  parameter int  ALLOC_W = DEFAULT_ALLOC_W,
  parameter int  FREE_W  = DEFAULT_FREE_W,
  localparam int IDX_W   = calc_idx_w(DEPTH),
  localparam int CNT_W   = calc_cnt_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [ALLOC_W-1:0]       alloc_req,
  output logic [ALLOC_W-1:0]       alloc_vld,
  output logic [ALLOC_W*IDX_W-1:0] alloc_idx,
  input  logic [FREE_W-1:0]        free_en,
  input  logic [FREE_W*IDX_W-1:0]  free_idx,
  output logic [CNT_W-1:0]         free_count,
  output logic                     none_free,
  output logic                     err_dbl_free
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;
  logic             none_free_q, none_free_d;
  logic             err_dbl_free_q, err_dbl_free_d;

  logic [ALLOC_W-1:0][DEPTH-1:0] stage_onehot;
  logic [ALLOC_W-1:0][IDX_W-1:0] stage_idx;
  logic [ALLOC_W-1:0]            stage_vld;

  logic [DEPTH-1:0] alloc_set, free_clr;
  logic [IDX_W-1:0] fi;
  logic [CNT_W-1:0] busy_cnt;
  logic             dbl;

  // Offers come only from registered state, so a slot freed this cycle is not offered until next.
  for (genvar g = 0; g < ALLOC_W; g++) begin : g_stage
    logic [DEPTH-1:0] mask_in;
    logic [DEPTH-1:0] onehot;
    logic [IDX_W-1:0] idx;
    logic             vld;

    if (g == 0) begin : g_first
      assign mask_in = '0;
    end else begin : g_next
      assign mask_in = g_stage[g-1].mask_in | g_stage[g-1].onehot;
    end

    masked_prio_enc #(.W(DEPTH), .IDX_W(IDX_W)) u_enc (
      .vec_i   (~busy_q),
      .mask_i  (mask_in),
      .idx_o   (idx),
      .vld_o   (vld),
      .onehot_o(onehot)
    );

    assign stage_onehot[g]              = onehot;
    assign stage_idx[g]                 = idx;
    assign stage_vld[g]                 = vld;
    assign alloc_idx[g*IDX_W +: IDX_W]  = idx;
  end

  assign alloc_vld = stage_vld;

  always_comb begin
    alloc_set = '0;
    free_clr  = '0;
    fi        = '0;
    dbl       = 1'b0;
    busy_cnt  = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (alloc_req[i] && stage_vld[i]) alloc_set = alloc_set | stage_onehot[i];
    end
    // A free of an already-free slot, or a repeat index across ports, is a double free.
    for (int j = 0; j < FREE_W; j++) begin
      if (free_en[j]) begin
        fi = free_idx[j*IDX_W +: IDX_W];
        if (!busy_q[fi] || free_clr[fi]) dbl = 1'b1;
        free_clr[fi] = 1'b1;
      end
    end
    // Allocation is OR-ed last so it wins over a same-cycle free of the offered slot.
    busy_d         = (busy_q & ~free_clr) | alloc_set;
    err_dbl_free_d = dbl;
    if (flush) begin
      busy_d         = '0;
      err_dbl_free_d = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      busy_cnt = busy_cnt + CNT_W'(busy_d[k]);
    end
    free_count_d = CNT_W'(DEPTH) - busy_cnt;
    none_free_d  = (free_count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= '0;
      free_count_q   <= CNT_W'(DEPTH);
      none_free_q    <= 1'b0;
      err_dbl_free_q <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      free_count_q   <= free_count_d;
      none_free_q    <= none_free_d;
      err_dbl_free_q <= err_dbl_free_d;
    end
  end

  assign free_count   = free_count_q;
  assign none_free    = none_free_q;
  assign err_dbl_free = err_dbl_free_q;

endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc: directed scenarios plus randomized traffic against a free-list model.
module tb_slot_alloc;

  localparam int DEPTH   = 16;
  localparam int ALLOC_W = 2;
  localparam int FREE_W  = 2;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;
  localparam int OBS_W   = ALLOC_W + ALLOC_W * IDX_W + CNT_W + 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  logic [ALLOC_W-1:0]       alloc_req;
  logic [ALLOC_W-1:0]       alloc_vld;
  logic [ALLOC_W*IDX_W-1:0] alloc_idx;
  logic [FREE_W-1:0]        free_en;
  logic [FREE_W*IDX_W-1:0]  free_idx;
  logic [CNT_W-1:0]         free_count;
  logic                     none_free;
  logic                     err_dbl_free;

  always #5 clk = ~clk;

  slot_alloc #(.DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .FREE_W(FREE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_req   (alloc_req),
    .alloc_vld   (alloc_vld),
    .alloc_idx   (alloc_idx),
    .free_en     (free_en),
    .free_idx    (free_idx),
    .free_count  (free_count),
    .none_free   (none_free),
    .err_dbl_free(err_dbl_free)
  );

  // Observation word: {alloc_vld, alloc_idx, free_count, none_free, err_dbl_free}
  logic [OBS_W-1:0] obs;
  assign obs = {alloc_vld, alloc_idx, free_count, none_free, err_dbl_free};

  bit   m_busy[DEPTH];
  int   m_count;
  bit   m_none;
  bit   m_err;
  int   vecs;
  int   miscompares;
  logic [OBS_W-1:0] exp_q[$];

  function automatic logic [OBS_W-1:0] model_obs();
    int                       fl[$];
    logic [ALLOC_W-1:0]       v;
    logic [ALLOC_W*IDX_W-1:0] ix;
    v  = '0;
    ix = '0;
    for (int s = 0; s < DEPTH; s++) if (!m_busy[s]) fl.push_back(s);
    for (int i = 0; i < ALLOC_W; i++) begin
      if (i < fl.size()) begin
        v[i] = 1'b1;
        ix[i*IDX_W +: IDX_W] = IDX_W'(fl[i]);
      end
    end
    return {v, ix, CNT_W'(m_count), m_none, m_err};
  endfunction

  task automatic model_step(input logic [ALLOC_W-1:0] req, input logic [FREE_W-1:0] fen,
                            input logic [FREE_W*IDX_W-1:0] fidx, input logic fls, input logic r);
    int fl[$];
    bit nb[DEPTH];
    int idx[FREE_W];
    int busy_n;
    if (r || fls) begin
      for (int s = 0; s < DEPTH; s++) m_busy[s] = 1'b0;
      m_count = DEPTH;
      m_none  = 1'b0;
      m_err   = 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) if (!m_busy[s]) fl.push_back(s);
      nb    = m_busy;
      m_err = 1'b0;
      for (int j = 0; j < FREE_W; j++) idx[j] = int'(fidx[j*IDX_W +: IDX_W]);
      for (int j = 0; j < FREE_W; j++) begin
        if (fen[j]) begin
          if (!m_busy[idx[j]]) m_err = 1'b1;
          for (int k = 0; k < j; k++) if (fen[k] && idx[k] == idx[j]) m_err = 1'b1;
          if (m_busy[idx[j]]) nb[idx[j]] = 1'b0;
        end
      end
      for (int i = 0; i < ALLOC_W; i++) if (req[i] && i < fl.size()) nb[fl[i]] = 1'b1;
      m_busy = nb;
      busy_n = 0;
      for (int s = 0; s < DEPTH; s++) busy_n += int'(m_busy[s]);
      m_count = DEPTH - busy_n;
      m_none  = (m_count == 0);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic [ALLOC_W-1:0] req, input logic [FREE_W-1:0] fen,
                       input logic [FREE_W*IDX_W-1:0] fidx, input logic fls, input logic r);
    @(negedge clk);
    alloc_req = req;
    free_en   = fen;
    free_idx  = fidx;
    flush     = fls;
    rst       = r;
    @(posedge clk);
    model_step(req, fen, fidx, fls, r);
    #1;
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b11, 8'h35, 1'b0, 1'b1);
    vecs++;
    if (obs !== {2'b11, 8'h10, 5'd16, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs, {2'b11, 8'h10, 5'd16, 1'b0, 1'b0});
    end
    drive(2'b00, 2'b00, 8'h00, 1'b0, 1'b0);
    vecs++;
    if (obs !== model_obs()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", obs, model_obs());
    end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 8; c++) begin
      drive(2'b11, 2'b00, 8'h00, 1'b0, 1'b0);
      vecs++;
      if (obs !== model_obs()) begin
        miscompares++;
        $display("FAIL fill_cycle%0d: got %h expected %h", c, obs, model_obs());
      end
    end
    vecs++;
    if (obs !== {2'b00, 8'h00, 5'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_full: got %h expected %h", obs, {2'b00, 8'h00, 5'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_no_bypass();
    drive(2'b11, 2'b01, 8'h05, 1'b0, 1'b0);
    vecs++;
    if (obs !== {2'b01, 8'h05, 5'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL no_bypass: got %h expected %h", obs, {2'b01, 8'h05, 5'd1, 1'b0, 1'b0});
    end
    drive(2'b11, 2'b00, 8'h00, 1'b0, 1'b0);
    vecs++;
    if (obs !== {2'b00, 8'h00, 5'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL retake_5: got %h expected %h", obs, {2'b00, 8'h00, 5'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_port1_only();
    drive(2'b00, 2'b11, 8'h10, 1'b0, 1'b0);
    drive(2'b00, 2'b11, 8'h32, 1'b0, 1'b0);
    drive(2'b10, 2'b00, 8'h00, 1'b0, 1'b0);
    vecs++;
    if (obs !== {2'b11, 8'h20, 5'd3, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL port1_only: got %h expected %h", obs, {2'b11, 8'h20, 5'd3, 1'b0, 1'b0});
    end
  endtask

  task automatic test_dbl_free();
    drive(2'b11, 2'b00, 8'h00, 1'b0, 1'b0);
    drive(2'b01, 2'b00, 8'h00, 1'b0, 1'b0);
    drive(2'b00, 2'b11, 8'h33, 1'b0, 1'b0);
    vecs++;
    if (obs !== {2'b01, 8'h03, 5'd1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL dup_port_free: got %h expected %h", obs, {2'b01, 8'h03, 5'd1, 1'b0, 1'b1});
    end
    drive(2'b00, 2'b01, 8'h09, 1'b0, 1'b0);
    vecs++;
    if (obs !== {2'b11, 8'h93, 5'd2, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL err_one_cycle: got %h expected %h", obs, {2'b11, 8'h93, 5'd2, 1'b0, 1'b0});
    end
    drive(2'b00, 2'b01, 8'h09, 1'b0, 1'b0);
    vecs++;
    if (obs !== {2'b11, 8'h93, 5'd2, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL free_of_free: got %h expected %h", obs, {2'b11, 8'h93, 5'd2, 1'b0, 1'b1});
    end
    drive(2'b01, 2'b01, 8'h03, 1'b0, 1'b0);
    vecs++;
    if (obs !== {2'b01, 8'h09, 5'd1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL alloc_wins: got %h expected %h", obs, {2'b01, 8'h09, 5'd1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_flush();
    drive(2'b11, 2'b11, 8'h21, 1'b1, 1'b0);
    vecs++;
    if (obs !== {2'b11, 8'h10, 5'd16, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL flush: got %h expected %h", obs, {2'b11, 8'h10, 5'd16, 1'b0, 1'b0});
    end
    drive(2'b11, 2'b00, 8'h00, 1'b0, 1'b0);
    drive(2'b00, 2'b11, 8'hff, 1'b0, 1'b0);
    drive(2'b11, 2'b11, 8'h01, 1'b1, 1'b1);
    vecs++;
    if (obs !== {2'b11, 8'h10, 5'd16, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL flush_rst: got %h expected %h", obs, {2'b11, 8'h10, 5'd16, 1'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [OBS_W-1:0] exp_v;
    logic [FREE_W*IDX_W-1:0] fidx;
    for (int c = 0; c < 400; c++) begin
      fidx = {IDX_W'($urandom_range(0, DEPTH - 1)), IDX_W'($urandom_range(0, DEPTH - 1))};
      drive(ALLOC_W'($urandom_range(0, 3)), FREE_W'($urandom_range(0, 3)), fidx,
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
      exp_q.push_back(model_obs());
      exp_v = exp_q.pop_front();
      vecs++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h expected %h", c, obs, exp_v);
      end
    end
  endtask

  initial begin
    vecs        = 0;
    miscompares = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    alloc_req   = '0;
    free_en     = '0;
    free_idx    = '0;
    test_reset();
    test_fill();
    test_no_bypass();
    test_port1_only();
    test_dbl_free();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
